axi_eth_tx_arb: RTL and testbench
=================================

AXI_ETH_TX_ARB -- requirements
Module: axi_eth_tx_arb

Interface
REQ-001 SHALL have parameter STRICT_PORT0, default 1; 1 = port 0 (ARP) always wins, 0 = pure round-robin.
REQ-002 SHALL have parameter CNT_W, default 16; width of each per-port frame counter.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port areset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have, for N in 0..3, port sN_req  in  1  requester N has a frame pending, with header stable while high.
REQ-006 SHALL have, for N in 0..3, port sN_ack  out  1  one-cycle pulse meaning the header is captured and the grant has started.
REQ-007 SHALL have, for N in 0..3, ports sN_dst_mac  in  48, sN_src_mac  in  48 and sN_ethertype  in  16; requester header fields.
REQ-008 SHALL have, for N in 0..3, ports sN_axis_tdata  in  8, sN_axis_tlast  in  1, sN_axis_tvalid  in  1 and sN_axis_tready  out  1; requester payload stream.
REQ-009 SHALL have ports m_req  out  1, m_ack  in  1 (one-cycle pulse), m_dst_mac  out  48, m_src_mac  out  48 and m_ethertype  out  16; header handshake toward the Ethernet TX port.
REQ-010 SHALL have ports m_axis_tdata  out  8, m_axis_tlast  out  1, m_axis_tvalid  out  1 and m_axis_tready  in  1; payload toward the Ethernet TX port.
REQ-011 SHALL have ports busy  out  1, grant_id  out  2 and frame_cnt  out  4*CNT_W; status outputs, with port N's counter at bits [N*CNT_W +: CNT_W].

Function
REQ-012 SHALL implement states IDLE, HDR and STREAM.
REQ-013 IDLE SHALL, on any sN_req=1, select a winner, register its header into m_* header outputs, set grant_id, pulse sN_ack for exactly one cycle (the cycle after selection) and enter HDR.
REQ-014 Winner selection SHALL be round-robin starting at rr_ptr, where rr_ptr resets to 0 and becomes grant_id+1 mod 4 on frame completion; with STRICT_PORT0=1, s0_req=1 overrides the round-robin choice.
REQ-015 HDR SHALL hold m_req=1 until the cycle m_ack=1 is sampled, then drop m_req and enter STREAM the following cycle.
REQ-016 STREAM SHALL combinationally route the granted stream: m_axis_tdata/tlast/tvalid come from sGRANT, sGRANT_axis_tready = m_axis_tready, and every other sN_axis_tready = 0.
REQ-017 In IDLE and HDR, m_axis_tvalid SHALL be 0 and all sN_axis_tready SHALL be 0.
REQ-018 STREAM SHALL, on a beat with tvalid & tready & tlast, increment frame_cnt[grant_id] (wrapping from 2^CNT_W-1 to 0), update rr_ptr and return to IDLE; re-arbitration occurs no earlier than the next cycle.
REQ-019 Minimum gap SHALL be 1 idle cycle between the final tlast beat and the next sN_ack pulse.
REQ-020 m_ack arriving outside HDR SHALL be ignored.
REQ-021 A requester dropping sN_req after being granted SHALL NOT abort the frame; the grant persists until tlast.
REQ-022 busy SHALL be 1 in HDR and STREAM, and 0 in IDLE.
REQ-023 Header outputs SHALL remain stable from HDR entry until STREAM exit.

Reset
REQ-024 areset=1 SHALL immediately force state to IDLE, rr_ptr=0, grant_id=0, every frame_cnt=0, and m_req, m_axis_tvalid, all sN_ack, all sN_axis_tready and busy to 0; header outputs go to 0.
REQ-025 Reset during HDR or STREAM SHALL abandon the frame without emitting tlast; after release the block resumes from IDLE.

Structure
REQ-026 The shared package SHALL hold the state enum (IDLE, HDR, STREAM), the port count constant (4) and the eth header struct (dst_mac, src_mac, ethertype).
REQ-027 Round-robin selection SHALL be a sub-module rr_arb4 (4 request bits, pointer and strict-0 flag in; 2-bit index and valid out), purely combinational.

Verification
REQ-028 s1_req alone, header dst=FF..FF, ethertype=0806, 3 bytes then tlast -> s1_ack one pulse; m_req held until m_ack; 3 bytes on m_axis in order; frame_cnt[1]=1.
REQ-029 s1, s2 and s3 requesting continuously, STRICT_PORT0=0 -> grant order 1,2,3,1; each frame_cnt increments once per frame.
REQ-030 s0 and s2 requesting with STRICT_PORT0=1 -> s0 wins every arbitration while s0_req=1; s2 is served only after s0_req=0.
REQ-031 m_axis_tready toggled 1,0,0,1 during STREAM -> no byte dropped or duplicated; the granted requester's tready mirrors it and non-granted treadys stay 0.
REQ-032 areset asserted in the middle of STREAM -> all outputs 0 in the same cycle; a subsequent s3 frame completes normally with frame_cnt[3]=1.
REQ-033 frame_cnt[0] preset by 65535 frames (CNT_W=16) -> the next frame wraps the counter to 0.

Source files
------------

// File: rtl/axi_eth_tx_arb_pkg.sv
// Shared types for the Ethernet TX arbiter: FSM states, port count, header record.
package axi_eth_tx_arb_pkg;
    localparam int NUM_PORTS = 4;

    typedef enum logic [1:0] {IDLE, HDR, STREAM} state_t;

    typedef struct packed {
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [15:0] ethertype;
    } eth_hdr_t;
endpackage

// File: rtl/axi_eth_tx_arb_rr_arb4.sv
// Combinational 4-way round-robin picker with optional strict priority for port 0.
module rr_arb4
    import axi_eth_tx_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [1:0]           ptr,
    input  logic                 strict0,
    output logic [1:0]           idx,
    output logic                 vld
);
    always_comb begin
        idx = ptr;
        vld = |req;
        // Walk offsets high to low so the closest requester at or after ptr wins.
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req[ptr + 2'(i)]) idx = ptr + 2'(i);
        end
        if (strict0 && req[0]) idx = 2'd0;
    end
endmodule

// File: rtl/axi_eth_tx_arb.sv
// Four-requester arbiter feeding one Ethernet TX port: header handshake, then payload mux.
module axi_eth_tx_arb
    import axi_eth_tx_arb_pkg::*;
#(
    parameter bit STRICT_PORT0 = 1'b1,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               areset,
    input  logic               s0_req,
    output logic               s0_ack,
    input  logic [47:0]        s0_dst_mac,
    input  logic [47:0]        s0_src_mac,
    input  logic [15:0]        s0_ethertype,
    input  logic [7:0]         s0_axis_tdata,
    input  logic               s0_axis_tlast,
    input  logic               s0_axis_tvalid,
    output logic               s0_axis_tready,
    input  logic               s1_req,
    output logic               s1_ack,
    input  logic [47:0]        s1_dst_mac,
    input  logic [47:0]        s1_src_mac,
    input  logic [15:0]        s1_ethertype,
    input  logic [7:0]         s1_axis_tdata,
    input  logic               s1_axis_tlast,
    input  logic               s1_axis_tvalid,
    output logic               s1_axis_tready,
    input  logic               s2_req,
    output logic               s2_ack,
    input  logic [47:0]        s2_dst_mac,
    input  logic [47:0]        s2_src_mac,
    input  logic [15:0]        s2_ethertype,
    input  logic [7:0]         s2_axis_tdata,
    input  logic               s2_axis_tlast,
    input  logic               s2_axis_tvalid,
    output logic               s2_axis_tready,
    input  logic               s3_req,
    output logic               s3_ack,
    input  logic [47:0]        s3_dst_mac,
    input  logic [47:0]        s3_src_mac,
    input  logic [15:0]        s3_ethertype,
    input  logic [7:0]         s3_axis_tdata,
    input  logic               s3_axis_tlast,
    input  logic               s3_axis_tvalid,
    output logic               s3_axis_tready,
    output logic               m_req,
    input  logic               m_ack,
    output logic [47:0]        m_dst_mac,
    output logic [47:0]        m_src_mac,
    output logic [15:0]        m_ethertype,
    output logic [7:0]         m_axis_tdata,
    output logic               m_axis_tlast,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               busy,
    output logic [1:0]         grant_id,
    output logic [4*CNT_W-1:0] frame_cnt
);
    logic [NUM_PORTS-1:0]          req_v, tlast_v, tvalid_v, tready_v, ack_q;
    logic [NUM_PORTS-1:0][7:0]     tdata_v;
    eth_hdr_t [NUM_PORTS-1:0]      hdr_v;
    eth_hdr_t                      hdr_q;
    state_t                        state, state_nxt;
    logic [1:0]                    grant_q, rr_ptr, win_idx;
    logic                          win_vld, streaming, beat_last;

    assign req_v    = {s3_req, s2_req, s1_req, s0_req};
    assign tlast_v  = {s3_axis_tlast, s2_axis_tlast, s1_axis_tlast, s0_axis_tlast};
    assign tvalid_v = {s3_axis_tvalid, s2_axis_tvalid, s1_axis_tvalid, s0_axis_tvalid};
    assign tdata_v  = {s3_axis_tdata, s2_axis_tdata, s1_axis_tdata, s0_axis_tdata};
    assign hdr_v[0] = {s0_dst_mac, s0_src_mac, s0_ethertype};
    assign hdr_v[1] = {s1_dst_mac, s1_src_mac, s1_ethertype};
    assign hdr_v[2] = {s2_dst_mac, s2_src_mac, s2_ethertype};
    assign hdr_v[3] = {s3_dst_mac, s3_src_mac, s3_ethertype};

    rr_arb4 u_arb (
        .req     (req_v),
        .ptr     (rr_ptr),
        .strict0 (STRICT_PORT0),
        .idx     (win_idx),
        .vld     (win_vld)
    );

    // Payload path is gated by state so reset silences it without waiting for a clock.
    assign streaming     = (state == STREAM);
    assign m_axis_tdata  = streaming ? tdata_v[grant_q] : 8'h00;
    assign m_axis_tvalid = streaming & tvalid_v[grant_q];
    assign m_axis_tlast  = streaming & tlast_v[grant_q];
    assign beat_last     = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    always_comb begin
        tready_v = '0;
        if (streaming) tready_v[grant_q] = m_axis_tready;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_vld)   state_nxt = HDR;
            HDR:     if (m_ack)     state_nxt = STREAM;
            STREAM:  if (beat_last) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            grant_q <= 2'd0;
            rr_ptr  <= 2'd0;
            hdr_q   <= '0;
            ack_q   <= '0;
        end else begin
            ack_q <= '0;
            if (state == IDLE && win_vld) begin
                grant_q        <= win_idx;
                hdr_q          <= hdr_v[win_idx];
                ack_q[win_idx] <= 1'b1;
            end
            if (beat_last) rr_ptr <= grant_q + 2'd1;
        end
    end

    for (genvar n = 0; n < NUM_PORTS; n++) begin : g_cnt
        logic [CNT_W-1:0] cnt;
        always_ff @(posedge clk or posedge areset) begin
            if (areset)                              cnt <= '0;
            else if (beat_last && grant_q == 2'(n))  cnt <= cnt + 1'b1;
        end
        assign frame_cnt[n*CNT_W +: CNT_W] = cnt;
    end

    assign {s3_ack, s2_ack, s1_ack, s0_ack} = ack_q;
    assign {s3_axis_tready, s2_axis_tready, s1_axis_tready, s0_axis_tready} = tready_v;
    assign m_req       = (state == HDR);
    assign busy        = (state != IDLE);
    assign grant_id    = grant_q;
    assign m_dst_mac   = hdr_q.dst_mac;
    assign m_src_mac   = hdr_q.src_mac;
    assign m_ethertype = hdr_q.ethertype;
endmodule

// File: tb/tb_axi_eth_tx_arb.sv
// Directed bench: frame table (arbitration order, header, payload, counters) plus reset and wrap sequences.
module tb_axi_eth_tx_arb;
    localparam int CNT_W = 16;
    localparam int RR_W  = 4;

    logic clk = 1'b0;
    logic areset;
    always #5 clk = ~clk;

    logic [3:0]        req, ack, tready, tlast, tvalid, rr_ack, rr_tready;
    logic [3:0][47:0]  dst, src;
    logic [3:0][15:0]  et;
    logic [3:0][7:0]   tdata;
    logic              m_ack, m_tready;
    logic              m_req, m_tlast, m_tvalid, busy;
    logic [47:0]       m_dst, m_src;
    logic [15:0]       m_et;
    logic [7:0]        m_tdata;
    logic [1:0]        grant;
    logic [4*CNT_W-1:0] frame_cnt;
    logic              rr_m_req, rr_m_tlast, rr_m_tvalid, rr_busy;
    logic [47:0]       rr_m_dst, rr_m_src;
    logic [15:0]       rr_m_et;
    logic [7:0]        rr_m_tdata;
    logic [1:0]        rr_grant;
    logic [4*RR_W-1:0] rr_frame_cnt;

    int len[4];
    int bidx[4];
    int exp_cnt[4];
    int checks = 0;
    int errors = 0;

    // Requester sources: always valid, byte = port*64 + beat index, tlast on beat len-1.
    assign tvalid = 4'hF;
    always_comb begin
        for (int p = 0; p < 4; p++) begin
            tdata[p] = 8'(p * 64 + bidx[p]);
            tlast[p] = (bidx[p] == len[p] - 1);
        end
    end
    always @(posedge clk or posedge areset) begin
        if (areset) begin
            for (int p = 0; p < 4; p++) bidx[p] <= 0;
        end else begin
            for (int p = 0; p < 4; p++)
                if (tready[p]) bidx[p] <= (bidx[p] == len[p] - 1) ? 0 : bidx[p] + 1;
        end
    end

    axi_eth_tx_arb #(.STRICT_PORT0(1'b1), .CNT_W(CNT_W)) dut (
        .clk(clk), .areset(areset),
        .s0_req(req[0]), .s0_ack(ack[0]), .s0_dst_mac(dst[0]), .s0_src_mac(src[0]), .s0_ethertype(et[0]),
        .s0_axis_tdata(tdata[0]), .s0_axis_tlast(tlast[0]), .s0_axis_tvalid(tvalid[0]), .s0_axis_tready(tready[0]),
        .s1_req(req[1]), .s1_ack(ack[1]), .s1_dst_mac(dst[1]), .s1_src_mac(src[1]), .s1_ethertype(et[1]),
        .s1_axis_tdata(tdata[1]), .s1_axis_tlast(tlast[1]), .s1_axis_tvalid(tvalid[1]), .s1_axis_tready(tready[1]),
        .s2_req(req[2]), .s2_ack(ack[2]), .s2_dst_mac(dst[2]), .s2_src_mac(src[2]), .s2_ethertype(et[2]),
        .s2_axis_tdata(tdata[2]), .s2_axis_tlast(tlast[2]), .s2_axis_tvalid(tvalid[2]), .s2_axis_tready(tready[2]),
        .s3_req(req[3]), .s3_ack(ack[3]), .s3_dst_mac(dst[3]), .s3_src_mac(src[3]), .s3_ethertype(et[3]),
        .s3_axis_tdata(tdata[3]), .s3_axis_tlast(tlast[3]), .s3_axis_tvalid(tvalid[3]), .s3_axis_tready(tready[3]),
        .m_req(m_req), .m_ack(m_ack), .m_dst_mac(m_dst), .m_src_mac(m_src), .m_ethertype(m_et),
        .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .busy(busy), .grant_id(grant), .frame_cnt(frame_cnt)
    );

    // Round-robin, narrow-counter instance sharing the same inputs; checked only while it tracks dut.
    axi_eth_tx_arb #(.STRICT_PORT0(1'b0), .CNT_W(RR_W)) dut_rr (
        .clk(clk), .areset(areset),
        .s0_req(req[0]), .s0_ack(rr_ack[0]), .s0_dst_mac(dst[0]), .s0_src_mac(src[0]), .s0_ethertype(et[0]),
        .s0_axis_tdata(tdata[0]), .s0_axis_tlast(tlast[0]), .s0_axis_tvalid(tvalid[0]), .s0_axis_tready(rr_tready[0]),
        .s1_req(req[1]), .s1_ack(rr_ack[1]), .s1_dst_mac(dst[1]), .s1_src_mac(src[1]), .s1_ethertype(et[1]),
        .s1_axis_tdata(tdata[1]), .s1_axis_tlast(tlast[1]), .s1_axis_tvalid(tvalid[1]), .s1_axis_tready(rr_tready[1]),
        .s2_req(req[2]), .s2_ack(rr_ack[2]), .s2_dst_mac(dst[2]), .s2_src_mac(src[2]), .s2_ethertype(et[2]),
        .s2_axis_tdata(tdata[2]), .s2_axis_tlast(tlast[2]), .s2_axis_tvalid(tvalid[2]), .s2_axis_tready(rr_tready[2]),
        .s3_req(req[3]), .s3_ack(rr_ack[3]), .s3_dst_mac(dst[3]), .s3_src_mac(src[3]), .s3_ethertype(et[3]),
        .s3_axis_tdata(tdata[3]), .s3_axis_tlast(tlast[3]), .s3_axis_tvalid(tvalid[3]), .s3_axis_tready(rr_tready[3]),
        .m_req(rr_m_req), .m_ack(m_ack), .m_dst_mac(rr_m_dst), .m_src_mac(rr_m_src), .m_ethertype(rr_m_et),
        .m_axis_tdata(rr_m_tdata), .m_axis_tlast(rr_m_tlast), .m_axis_tvalid(rr_m_tvalid), .m_axis_tready(m_tready),
        .busy(rr_busy), .grant_id(rr_grant), .frame_cnt(rr_frame_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] cnt16();
        return {16'(exp_cnt[3]), 16'(exp_cnt[2]), 16'(exp_cnt[1]), 16'(exp_cnt[0])};
    endfunction

    function automatic logic [63:0] cnt4();
        return {48'h0, 4'(exp_cnt[3]), 4'(exp_cnt[2]), 4'(exp_cnt[1]), 4'(exp_cnt[0])};
    endfunction

    typedef struct {
        logic [3:0] req;
        int         len;
        logic [3:0] tpat;
        int         ack_dly;
        bit         drop;
        bit         chk_rr;
        logic [1:0] grant;
    } vec_t;

    // Waits (bounded) for the ack pulse at a negedge; returns with #1 settle applied.
    task automatic wait_ack();
        int n = 0;
        @(negedge clk); #1;
        while (ack == 4'b0 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
    endtask

    task automatic run_frame(input vec_t v);
        int g = int'(v.grant);
        int k = 0;
        bit done = 0;
        bit route_ok = 1;
        bit data_ok = 1;
        logic [7:0] got[$];
        req = v.req;
        len[g] = v.len;
        wait_ack();
        chk("ack_onehot", 64'(ack), 64'(4'b1 << g));
        chk("grant_id", 64'(grant), 64'(g));
        chk("m_req_hdr", {m_req, busy}, 2'b11);
        chk("hdr_dst", m_dst, dst[g]);
        chk("hdr_src", m_src, src[g]);
        chk("hdr_et", m_et, et[g]);
        chk("hdr_quiet", {m_tvalid, tready}, 5'b0);
        if (v.chk_rr) chk("rr_grant", 64'(rr_grant), 64'(g));
        if (v.drop) req[g] = 1'b0;
        repeat (v.ack_dly) begin
            @(negedge clk); #1;
            chk("m_req_wait", {m_req, ack}, {1'b1, 4'b0});
        end
        m_ack = 1'b1;
        while (!done && k < 40) begin
            @(negedge clk);
            m_ack = 1'b0;
            m_tready = v.tpat[k % 4];
            #1;
            if (k == 0) chk("m_req_drop", {m_req, busy}, 2'b01);
            if (tready != (m_tready ? (4'b1 << g) : 4'b0)) route_ok = 0;
            if (m_tvalid && m_tready) begin
                got.push_back(m_tdata);
                done = m_tlast;
                if (done) chk("hdr_stable", {m_et, m_dst}, {et[g], dst[g]});
            end
            k++;
        end
        chk("stream_done", 64'(done), 64'(1));
        chk("tready_route", 64'(route_ok), 64'(1));
        chk("byte_count", 64'(got.size()), 64'(v.len));
        foreach (got[i]) if (got[i] != 8'(g * 64 + i)) data_ok = 0;
        chk("payload", 64'(data_ok), 64'(1));
        @(negedge clk); #1;
        chk("gap_idle", {busy, ack}, 5'b0);
        exp_cnt[g] = (exp_cnt[g] + 1) & 32'hFFFF;
        chk("frame_cnt", frame_cnt, cnt16());
        if (v.chk_rr) chk("rr_frame_cnt", 64'(rr_frame_cnt), cnt4());
    endtask

    vec_t vecs[10];

    initial begin
        vec_t v;
        vecs[0] = '{4'b1110, 2, 4'hF,    1, 1'b0, 1'b1, 2'd1};
        vecs[1] = '{4'b1110, 3, 4'hF,    1, 1'b0, 1'b1, 2'd2};
        vecs[2] = '{4'b1110, 1, 4'hF,    2, 1'b0, 1'b1, 2'd3};
        vecs[3] = '{4'b1110, 2, 4'hF,    1, 1'b0, 1'b1, 2'd1};
        vecs[4] = '{4'b0010, 3, 4'hF,    3, 1'b0, 1'b1, 2'd1};
        vecs[5] = '{4'b0101, 2, 4'hF,    1, 1'b0, 1'b0, 2'd0};
        vecs[6] = '{4'b0101, 1, 4'hF,    1, 1'b0, 1'b0, 2'd0};
        vecs[7] = '{4'b0100, 2, 4'hF,    1, 1'b0, 1'b0, 2'd2};
        vecs[8] = '{4'b1000, 4, 4'b1001, 1, 1'b0, 1'b0, 2'd3};
        vecs[9] = '{4'b0001, 2, 4'b1011, 1, 1'b1, 1'b0, 2'd0};

        for (int p = 0; p < 4; p++) begin
            dst[p] = 48'h0200_0000_0000 + 48'(p);
            src[p] = 48'h0A00_0000_0010 + 48'(p);
            et[p]  = 16'h0800 + 16'(p);
            len[p] = 1;
            exp_cnt[p] = 0;
        end
        dst[1] = 48'hFFFF_FFFF_FFFF;
        et[1]  = 16'h0806;
        areset = 1'b1;
        req = 4'b0;
        m_ack = 1'b0;
        m_tready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_state", {m_req, busy, ack, tready, m_tvalid, grant}, 13'b0);
        chk("reset_cnt", frame_cnt, 64'h0);
        @(negedge clk);
        areset = 1'b0;

        // Stray m_ack while idle must not start anything.
        m_ack = 1'b1;
        @(negedge clk);
        m_ack = 1'b0;
        #1;
        chk("idle_m_ack", {busy, m_req, ack}, 6'b0);

        for (int i = 0; i < 10; i++) run_frame(vecs[i]);

        // Reset in the middle of an s3 frame.
        req = 4'b1000;
        len[3] = 5;
        wait_ack();
        chk("pre_rst_grant", 64'(grant), 64'(3));
        m_ack = 1'b1;
        m_tready = 1'b1;
        @(negedge clk);
        m_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("pre_rst_stream", {busy, m_tvalid}, 2'b11);
        areset = 1'b1;
        #1;
        chk("rst_outputs", {m_req, m_tvalid, m_tlast, m_tdata, ack, tready, busy, grant}, 23'b0);
        chk("rst_cnt", frame_cnt, 64'h0);
        chk("rst_hdr", {m_et, m_dst}, 64'h0);
        chk("rst_rr", {rr_busy, rr_m_tvalid, rr_frame_cnt}, 18'b0);
        req = 4'b0;
        @(negedge clk);
        areset = 1'b0;
        for (int p = 0; p < 4; p++) exp_cnt[p] = 0;
        v = '{4'b1000, 3, 4'hF, 1, 1'b0, 1'b1, 2'd3};
        run_frame(v);

        // 16 single-beat s0 frames: the 4-bit counter wraps, the 16-bit one reaches 16.
        for (int i = 0; i < 16; i++) begin
            v = '{4'b0001, 1, 4'hF, 1, 1'b0, 1'b1, 2'd0};
            run_frame(v);
            if (i == 14) chk("rr_cnt_max", 64'(rr_frame_cnt[3:0]), 64'hF);
        end
        chk("rr_cnt_wrap", 64'(rr_frame_cnt[3:0]), 64'h0);
        chk("cnt16_no_wrap", 64'(frame_cnt[15:0]), 64'd16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
